// File: rtl/sram_arb_2x1.sv
// Two-master arbiter in front of a single-port SRAM, one-cycle read latency.
// Define SRAM_ARB_RR_EN for round-robin on contention; default is fixed m0 priority.
module sram_arb_2x1 #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          m0_req,
    input  logic [3:0]    m0_wen,
    input  logic [DW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic [3:0]    m1_wen,
    input  logic [DW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    output logic          sram_en,
    output logic [3:0]    sram_wen,
    output logic [DW-1:0] sram_addr,
    output logic [DW-1:0] sram_wdata,
    input  logic [DW-1:0] sram_rdata
);

    logic r_lg;
    logic r_pend;
    logic r_owner;
    logic w_pick1;
    logic w_g0;
    logic w_g1;
    logic w_rd;

`ifdef SRAM_ARB_RR_EN
    assign w_pick1 = ~r_lg;
`else
    // lg is kept up to date but never steers a fixed-priority grant
    assign w_pick1 = 1'b0 & ~r_lg;
`endif

    assign w_g0 = reset & m0_req & ~(m1_req & w_pick1);
    assign w_g1 = reset & m1_req & (~m0_req | w_pick1);

    assign m0_gnt = w_g0;
    assign m1_gnt = w_g1;

    always_comb begin
        sram_en    = w_g0 | w_g1;
        sram_wen   = 4'b0000;
        sram_addr  = '0;
        sram_wdata = '0;
        if (w_g1) begin
            sram_wen   = m1_wen;
            sram_addr  = m1_addr;
            sram_wdata = m1_wdata;
        end else if (w_g0) begin
            sram_wen   = m0_wen;
            sram_addr  = m0_addr;
            sram_wdata = m0_wdata;
        end
    end

    assign w_rd = sram_en & (sram_wen == 4'b0000);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pend  <= 1'b0;
            r_owner <= 1'b0;
            r_lg    <= 1'b1;
        end else begin
            r_pend <= w_rd;
            if (w_rd)
                r_owner <= w_g1;
            if (sram_en)
                r_lg <= w_g1;
        end
    end

    // A read in flight when reset asserts is dropped, not delivered
    assign m0_rvalid = reset & r_pend & ~r_owner;
    assign m1_rvalid = reset & r_pend & r_owner;
    assign m0_rdata  = m0_rvalid ? sram_rdata : '0;
    assign m1_rdata  = m1_rvalid ? sram_rdata : '0;

endmodule

// File: doc/sram_arb_2x1.md
SRAM_ARB_2X1 -- requirements
Module: sram_arb_2x1

Interface
REQ-001 SHALL have parameter DW, default 32: width of address, write-data and read-data buses.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  reset; synchronous, active-low.
REQ-004 SHALL have ports m0_req / m1_req  input  1  master n requests one transfer; master 0 is data, master 1 is instruction fetch.
REQ-005 SHALL have ports m0_wen / m1_wen  input  4  byte write enables; 4'b0000 means read.
REQ-006 SHALL have ports m0_addr / m1_addr  input  DW  transfer address.
REQ-007 SHALL have ports m0_wdata / m1_wdata  input  DW  write data.
REQ-008 SHALL have ports m0_gnt / m1_gnt  output  1  transfer accepted this cycle.
REQ-009 SHALL have ports m0_rvalid / m1_rvalid  output  1  read data valid for master n.
REQ-010 SHALL have ports m0_rdata / m1_rdata  output  DW  read data.
REQ-011 SHALL have ports sram_en  output 1, sram_wen  output 4, sram_addr  output DW, sram_wdata  output DW: shared SRAM request.
REQ-012 SHALL have port sram_rdata  input  DW  SRAM read data, valid one cycle after a read with sram_en=1.

Function
REQ-013 SHALL keep each master's req/wen/addr/wdata stable from request until the cycle its gnt is 1; a transfer completes in any cycle where mN_req=1 and mN_gnt=1.
REQ-014 SHALL derive gnt combinationally from current req and arbitration state; at most one gnt is 1 per cycle.
REQ-015 SHALL, when exactly one master requests, grant it in the same cycle.
REQ-016 SHALL drive sram_en = OR of granted req, sram_wen/addr/wdata from the granted master, and sram_wen = 4'b0000, sram_en = 0 when nothing is granted.
REQ-017 SHALL, on a granted read, register owner = granted master and pending = 1; the next cycle assert that master's rvalid for exactly one cycle with rdata = sram_rdata.
REQ-018 SHALL never assert rvalid for a granted write.
REQ-019 SHALL drive mN_rdata = 0 whenever mN_rvalid = 0.
REQ-020 SHALL accept a new grant in the same cycle as a pending rvalid, giving back-to-back reads one transfer per cycle.
REQ-021 SHALL keep a last-grant register (lg), updated only in cycles with a grant.
REQ-022 SHALL, on simultaneous requests, arbitrate per Configuration (REQ-026/027); the loser keeps req high and is granted no later than the next cycle under round-robin.

Reset
REQ-023 SHALL, while reset = 0 at a clock edge, clear pending and owner to 0 and set lg = 1 (master 1), so master 0 wins the first contention.
REQ-024 SHALL force m0_gnt, m1_gnt, sram_en, rvalids to 0 and sram_wen to 4'b0000 in every cycle reset = 0, regardless of req.
REQ-025 SHALL discard a read that is pending when reset asserts; no rvalid appears after reset deasserts.

Configuration
REQ-026 SHALL, with macro SRAM_ARB_RR_EN defined, grant on contention the master not equal to lg (round-robin).
REQ-027 SHALL, without SRAM_ARB_RR_EN, grant master 0 on every contention (fixed priority); lg is still maintained but unused.

Verification
REQ-028 SHALL check: reset = 0 for 3 cycles with both req = 1 -> both gnt = 0, sram_en = 0, no rvalid.
REQ-029 SHALL check: m0 read addr 0x0000_0040 alone, SRAM returns 0xDEAD_BEEF -> m0_gnt = 1 in cycle T, sram_addr = 0x40, m0_rvalid = 1 and m0_rdata = 0xDEAD_BEEF in T+1, m1_rvalid = 0.
REQ-030 SHALL check (RR_EN): both request reads continuously for 4 cycles after reset -> grants m0, m1, m0, m1; rvalids follow one cycle later to the matching owner.
REQ-031 SHALL check (no RR_EN): same stimulus -> m0 granted all 4 cycles, m1_gnt = 0 throughout.
REQ-032 SHALL check: m1 write wen = 4'b0011, addr 0x1000, wdata 0x1234_5678 -> sram_en = 1, sram_wen = 4'b0011, sram_wdata = 0x1234_5678 in grant cycle; no rvalid next cycle.
REQ-033 SHALL check: m0 read granted at T, reset = 0 at T+1 -> m0_rvalid = 0 at T+1 and after reset deasserts.
